// File: rtl/mac_seq_ctrl_if.sv
// Control/handshake bundle between the MAC sequencer and its stream source, datapath and consumer.
// master = sequencer side, slave = environment side.
interface mac_seq_ctrl_if #(
    parameter int LEN_W = 4
);
    logic             start;
    logic [LEN_W-1:0] len;
    logic             abort;
    logic             in_valid;
    logic             in_ready;
    logic             ld_op;
    logic             ld_acc;
    logic             clr_acc;
    logic             out_valid;
    logic             out_ready;
    logic             busy;
    logic [LEN_W-1:0] prod_cnt;

    modport master (
        input  start, len, abort, in_valid, out_ready,
        output in_ready, ld_op, ld_acc, clr_acc, out_valid, busy, prod_cnt
    );

    modport slave (
        output start, len, abort, in_valid, out_ready,
        input  in_ready, ld_op, ld_acc, clr_acc, out_valid, busy, prod_cnt
    );
endinterface

// File: rtl/mac_seq_ctrl.sv
// MAC sequencer: clears the accumulator, then loads/accumulates len operand pairs; start->out_valid in 2+2*len cycles.
// Input side stalls in FETCH until in_valid; result is held in DONE until out_ready; abort returns to IDLE.
module mac_seq_ctrl #(
    parameter int LEN_W = 4
) (
    input logic            clk,
    input logic            rst,
    mac_seq_ctrl_if.master bus
);
    typedef enum logic [2:0] {IDLE, CLEAR, FETCH, ACC, DONE} state_t;

    state_t           state_q;
    state_t           state_d;
    logic [LEN_W-1:0] rem_q;
    logic [LEN_W-1:0] prod_q;

    logic in_ready;
    logic ld_op;
    logic ld_acc;
    logic clr_acc;
    logic out_valid;
    logic abort_hit;

    assign abort_hit = bus.abort && (state_q != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            rem_q   <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && bus.start) begin
                rem_q  <= bus.len;
                prod_q <= '0;
            end else if (state_q == ACC && !bus.abort) begin
                rem_q  <= rem_q - 1'b1;
                prod_q <= prod_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        ld_op     = 1'b0;
        ld_acc    = 1'b0;
        clr_acc   = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) state_d = CLEAR;
            end
            CLEAR: begin
                clr_acc = 1'b1;
                state_d = (rem_q == '0) ? DONE : FETCH;
            end
            FETCH: begin
                in_ready = 1'b1;
                ld_op    = bus.in_valid;
                if (bus.in_valid) state_d = ACC;
            end
            ACC: begin
                ld_acc  = 1'b1;
                state_d = (rem_q == LEN_W'(1)) ? DONE : FETCH;
            end
            DONE: begin
                out_valid = 1'b1;
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Abort wins over everything: drop the job and leave the accumulator cleared.
        if (abort_hit) begin
            state_d   = IDLE;
            clr_acc   = 1'b1;
            in_ready  = 1'b0;
            ld_op     = 1'b0;
            ld_acc    = 1'b0;
            out_valid = 1'b0;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.ld_op     = ld_op;
    assign bus.ld_acc    = ld_acc;
    assign bus.clr_acc   = clr_acc;
    assign bus.out_valid = out_valid;
    assign bus.busy      = (state_q != IDLE);
    assign bus.prod_cnt  = prod_q;
endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Directed bench for mac_seq_ctrl with a behavioural MAC datapath driven by the controls and a result scoreboard.
module tb_mac_seq_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mac_seq_ctrl_if #(.LEN_W(4)) bus();

    mac_seq_ctrl #(.LEN_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Datapath model: operand registers and accumulator steered by the DUT controls.
    logic [7:0]  a_d, b_d, a_q, b_q;
    logic [19:0] acc;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q <= '0;
            b_q <= '0;
            acc <= '0;
        end else begin
            if (bus.ld_op) begin
                a_q <= a_d;
                b_q <= b_d;
            end
            if (bus.clr_acc)     acc <= '0;
            else if (bus.ld_acc) acc <= acc + a_q * b_q;
        end
    end

    int checks = 0;
    int errors = 0;
    int sb_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sb_check(input string tag, input int cnt);
        int e;
        chk({tag, "_sb_nonempty"}, 32'(sb_q.size() != 0), 1);
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk({tag, "_result"}, 32'(acc), e);
        end
        chk({tag, "_prod_cnt"}, 32'(bus.prod_cnt), cnt);
    endtask

    task automatic idle_outputs(input string tag);
        chk({tag, "_in_ready"},  32'(bus.in_ready), 0);
        chk({tag, "_ld_op"},     32'(bus.ld_op), 0);
        chk({tag, "_ld_acc"},    32'(bus.ld_acc), 0);
        chk({tag, "_clr_acc"},   32'(bus.clr_acc), 0);
        chk({tag, "_out_valid"}, 32'(bus.out_valid), 0);
        chk({tag, "_busy"},      32'(bus.busy), 0);
    endtask

    // Generic job: gap idle FETCH cycles before each pair; spam drives start throughout the job.
    task automatic do_job(input int n, input int gap, input bit spam, input string tag);
        int s;
        logic [3:0] l;
        s = 0;
        l = n[3:0];
        step();
        bus.start = 1'b1; bus.len = l; bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.abort = 1'b0;
        #1;
        chk({tag, "_idle_busy"}, 32'(bus.busy), 0);
        step();
        bus.start = spam;
        #1;
        chk({tag, "_clr"}, 32'(bus.clr_acc), 1);
        chk({tag, "_clr_ldop"}, 32'(bus.ld_op), 0);
        for (int p = 0; p < n; p++) begin
            for (int g = 0; g < gap; g++) begin
                step();
                bus.in_valid = 1'b0;
                #1;
                chk({tag, "_wait_rdy"}, 32'(bus.in_ready), 1);
                chk({tag, "_wait_ldop"}, 32'(bus.ld_op), 0);
            end
            step();
            bus.in_valid = 1'b1;
            a_d = 8'($urandom_range(0, 255));
            b_d = 8'($urandom_range(0, 255));
            #1;
            chk({tag, "_fetch_ldop"}, 32'(bus.ld_op), 1);
            chk({tag, "_fetch_ldacc"}, 32'(bus.ld_acc), 0);
            s += int'(a_d) * int'(b_d);
            step();
            bus.in_valid = 1'b0;
            #1;
            chk({tag, "_acc_ldacc"}, 32'(bus.ld_acc), 1);
            chk({tag, "_acc_ldop"}, 32'(bus.ld_op), 0);
            chk({tag, "_acc_clr"}, 32'(bus.clr_acc), 0);
        end
        sb_q.push_back(s);
        step();
        #1;
        chk({tag, "_done_valid"}, 32'(bus.out_valid), 1);
        chk({tag, "_done_ldop"}, 32'(bus.ld_op), 0);
        sb_check(tag, n);
        step();
        #1;
        chk({tag, "_done_hold"}, 32'(bus.out_valid), 1);
        chk({tag, "_done_busy"}, 32'(bus.busy), 1);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        bus.start = 1'b0;
        #1;
        chk({tag, "_after_busy"}, 32'(bus.busy), 0);
        chk({tag, "_after_valid"}, 32'(bus.out_valid), 0);
        step();
        #1;
        chk({tag, "_after2_busy"}, 32'(bus.busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        bus.start = 1'b0; bus.len = 4'd0; bus.abort = 1'b0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        a_d = 8'd0; b_d = 8'd0;

        // Reset state
        #3;
        idle_outputs("rst");
        chk("rst_prod_cnt", 32'(bus.prod_cnt), 0);
        @(negedge clk);
        rst = 1'b0;

        // Asynchronous reset in the middle of a len=5 job
        step();
        bus.start = 1'b1; bus.len = 4'd5; bus.in_valid = 1'b1;
        a_d = 8'd3; b_d = 8'd4;
        step(); bus.start = 1'b0;
        step();
        step(); bus.in_valid = 1'b0;
        step();
        #1;
        chk("t1_fetch_rdy", 32'(bus.in_ready), 1);
        chk("t1_fetch_cnt", 32'(bus.prod_cnt), 1);
        #2 rst = 1'b1;
        #1;
        idle_outputs("t1_async");
        chk("t1_async_cnt", 32'(bus.prod_cnt), 0);
        #1 rst = 1'b0;
        step();
        #1;
        chk("t1_stay_idle", 32'(bus.busy), 0);

        // Cycle-exact len=3 job with in_valid held high
        s = 0;
        for (int c = 0; c <= 11; c++) begin
            step();
            bus.start = (c == 0);
            bus.len = 4'd3;
            bus.in_valid = 1'b1;
            bus.out_ready = (c == 10);
            a_d = 8'($urandom_range(0, 255));
            b_d = 8'($urandom_range(0, 255));
            #1;
            chk("t2_clr",    32'(bus.clr_acc),   32'(c == 1));
            chk("t2_ld_op",  32'(bus.ld_op),     32'(c == 2 || c == 4 || c == 6));
            chk("t2_ld_acc", 32'(bus.ld_acc),    32'(c == 3 || c == 5 || c == 7));
            chk("t2_valid",  32'(bus.out_valid), 32'(c >= 8 && c <= 10));
            chk("t2_busy",   32'(bus.busy),      32'(c >= 1 && c <= 10));
            if (c == 2 || c == 4 || c == 6) s += int'(a_d) * int'(b_d);
            if (c == 7) sb_q.push_back(s);
            if (c == 8) sb_check("t2", 3);
        end
        bus.in_valid = 1'b0;

        // len=0, stalled len=2, and start pulses during a len=2 job
        do_job(0, 0, 1'b0, "t3");
        do_job(2, 4, 1'b0, "t4");
        do_job(2, 1, 1'b1, "t6");
        do_job(15, 0, 1'b0, "tmax");

        // Abort during the second FETCH of a len=4 job
        step();
        bus.start = 1'b1; bus.len = 4'd4; bus.in_valid = 1'b1;
        a_d = 8'd7; b_d = 8'd9;
        step(); bus.start = 1'b0;
        step();
        step();
        step();
        bus.abort = 1'b1;
        #1;
        chk("t5_abort_clr",   32'(bus.clr_acc), 1);
        chk("t5_abort_ldop",  32'(bus.ld_op), 0);
        chk("t5_abort_rdy",   32'(bus.in_ready), 0);
        chk("t5_abort_ldacc", 32'(bus.ld_acc), 0);
        step();
        bus.abort = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        chk("t5_idle_busy",  32'(bus.busy), 0);
        chk("t5_prod_cnt",   32'(bus.prod_cnt), 1);
        chk("t5_acc_clear",  32'(acc), 0);
        for (int k = 0; k < 3; k++) begin
            step();
            #1;
            chk("t5_no_valid", 32'(bus.out_valid), 0);
            chk("t5_cnt_hold", 32'(bus.prod_cnt), 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
